// File: rtl/jtag_bridge_pkg.sv
// Shared encodings for the JTAG command bridge: opcodes, cmd/resp field
// positions and the executor state type.
package jtag_bridge_pkg;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_SETADDR = 2'b01;
    localparam logic [1:0] OP_WRITE   = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    localparam int CMD_OP_HI    = 63;
    localparam int CMD_OP_LO    = 62;
    localparam int CMD_ADDR_LO  = 32;
    localparam int CMD_DATA_HI  = 31;
    localparam int CMD_CLR_BIT  = 0;

    localparam int RESP_BUSY_BIT = 63;
    localparam int RESP_ERR_BIT  = 62;
    localparam int RESP_PTR_HI   = 61;
    localparam int RESP_PTR_LO   = 32;
    localparam int PTR_FIELD_W   = RESP_PTR_HI - RESP_PTR_LO + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

endpackage

// File: rtl/jtag_bus_bridge.sv
// Executes JTAG-delivered peek/poke commands on a req/ack memory bus with an
// auto-incrementing word pointer and a sticky error flag.
module jtag_bus_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int ADDR_BITS = 30,
    parameter int TIMEOUT   = 255
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic [63:0]          cmd,
    input  logic                 cmd_stb,
    output logic [63:0]          resp,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [31:0]          bus_wdata,
    input  logic [31:0]          bus_rdata,
    input  logic                 bus_ack
);

    state_t                state, state_d;
    logic [ADDR_BITS-1:0]  ptr, ptr_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err, err_d;
    logic                  we_d;
    logic [ADDR_BITS-1:0]  addr_d;
    logic [31:0]           wdata_d;
    logic [15:0]           tmo_cnt, tmo_cnt_d;
    logic [1:0]            op;
    logic [PTR_FIELD_W-1:0] ptr_ext;

    assign op      = cmd[CMD_OP_HI:CMD_OP_LO];
    assign bus_req = (state == BUS);

    always_comb begin
        ptr_ext                = '0;
        ptr_ext[ADDR_BITS-1:0] = ptr;
    end

    assign resp = {bus_req, err, ptr_ext, rdata_q};

    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        rdata_d   = rdata_q;
        err_d     = err;
        we_d      = bus_we;
        addr_d    = bus_addr;
        wdata_d   = bus_wdata;
        tmo_cnt_d = tmo_cnt;
        case (state)
            IDLE: begin
                if (cmd_stb) begin
                    case (op)
                        OP_NOP: begin
                            if (cmd[CMD_CLR_BIT]) err_d = 1'b0;
                        end
                        OP_SETADDR: begin
                            ptr_d = cmd[CMD_ADDR_LO +: ADDR_BITS];
                        end
                        default: begin
                            we_d      = (op == OP_WRITE);
                            addr_d    = ptr;
                            wdata_d   = cmd[CMD_DATA_HI:0];
                            tmo_cnt_d = 16'(TIMEOUT - 1);
                            state_d   = BUS;
                        end
                    endcase
                end
            end
            BUS: begin
                // Any strobe here is an overrun and is dropped; an ack still
                // beats a simultaneous timeout expiry.
                if (cmd_stb) err_d = 1'b1;
                if (bus_ack) begin
                    state_d = IDLE;
                    ptr_d   = ptr + ADDR_BITS'(1);
                    if (!bus_we) rdata_d = bus_rdata;
                end else if (tmo_cnt == 16'd0) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            rdata_q   <= '0;
            err       <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_d;
            ptr       <= ptr_d;
            rdata_q   <= rdata_d;
            err       <= err_d;
            bus_we    <= we_d;
            bus_addr  <= addr_d;
            bus_wdata <= wdata_d;
            tmo_cnt   <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_jtag_bus_bridge.sv
// Scoreboarded bench for jtag_bus_bridge: a 30-bit instance driven through a
// modelled slave, and a 4-bit instance for pointer wrap.
module tb_jtag_bus_bridge;
    import jtag_bridge_pkg::*;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
    } bus_txn_t;

    logic        sysclk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] cmd = '0;
    logic        cmd_stb = 1'b0;
    logic [63:0] resp;
    logic        bus_req, bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    logic [63:0] s_cmd = '0;
    logic        s_stb = 1'b0;
    logic [63:0] s_resp;
    logic        s_req, s_we;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata;
    logic [31:0] s_rdata = '0;
    logic        s_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    bus_txn_t    exp_q[$];
    int          ack_delay = 1;
    logic [31:0] slave_rdata = '0;
    int          req_len = 0;
    bit          req_seen = 0;

    always #5 sysclk = ~sysclk;

    jtag_bus_bridge #(.ADDR_BITS(30), .TIMEOUT(4)) dut (
        .sysclk(sysclk), .reset_n(reset_n), .cmd(cmd), .cmd_stb(cmd_stb),
        .resp(resp), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    jtag_bus_bridge #(.ADDR_BITS(4), .TIMEOUT(4)) dut_small (
        .sysclk(sysclk), .reset_n(reset_n), .cmd(s_cmd), .cmd_stb(s_stb),
        .resp(s_resp), .bus_req(s_req), .bus_we(s_we), .bus_addr(s_addr),
        .bus_wdata(s_wdata), .bus_rdata(s_rdata), .bus_ack(s_ack)
    );

    // Slave model: checks each new access against the scoreboard and acks on
    // the ack_delay-th request cycle (0 = never ack).
    initial begin
        bus_txn_t t;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge sysclk);
            if (bus_req === 1'b1) begin
                if (!req_seen) begin
                    req_seen = 1;
                    req_len  = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL bus_txn unexpected access we=%b addr=%h", bus_we, bus_addr);
                    end else begin
                        t = exp_q.pop_front();
                        if (bus_we !== t.we || bus_addr !== t.addr || (t.we && bus_wdata !== t.wdata)) begin
                            errors++;
                            $display("[TB] FAIL bus_txn got we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                                     bus_we, bus_addr, bus_wdata, t.we, t.addr, t.wdata);
                        end
                    end
                end
                req_len++;
                bus_ack   = (req_len == ack_delay);
                bus_rdata = slave_rdata;
            end else begin
                req_seen = 0;
                bus_ack  = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [29:0] addr, input logic [31:0] data);
        cmd     = {op, addr, data};
        cmd_stb = 1'b1;
        tick();
        cmd_stb = 1'b0;
        cmd     = '0;
    endtask

    task automatic push_txn(input logic we, input logic [29:0] addr, input logic [31:0] wdata);
        bus_txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata;
        exp_q.push_back(t);
    endtask

    task automatic wait_not_busy(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound; i++) begin
            if (bus_req === 1'b0) break;
            tick();
        end
        if (bus_req === 1'b0) ok = 1;
    endtask

    task automatic test_reset();
        bit saw_req = 0;
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (resp !== 64'h0 || bus_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state resp=%h req=%b expected resp=0 req=0", resp, bus_req);
        end
        send_cmd(OP_NOP, 30'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            if (bus_req !== 1'b0) saw_req = 1;
            tick();
        end
        checks++;
        if (resp !== 64'h0 || saw_req) begin
            errors++;
            $display("[TB] FAIL nop_idle resp=%h saw_req=%b expected resp=0 saw_req=0", resp, saw_req);
        end
    endtask

    task automatic test_write();
        bit ok;
        send_cmd(OP_SETADDR, 30'h100, 32'h0);
        checks++;
        if (resp[61:32] !== 30'h100) begin
            errors++;
            $display("[TB] FAIL setaddr_ptr got=%h expected=%h", resp[61:32], 30'h100);
        end
        push_txn(1'b1, 30'h100, 32'hDEADBEEF);
        ack_delay = 3;
        send_cmd(OP_WRITE, 30'h0, 32'hDEADBEEF);
        checks++;
        if (bus_req !== 1'b1 || resp[63] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_start req=%b busy=%b expected 1 1", bus_req, resp[63]);
        end
        wait_not_busy(50, ok);
        checks++;
        if (!ok || req_len != 3 || resp !== {2'b00, 30'h101, 32'h0}) begin
            errors++;
            $display("[TB] FAIL write_done ok=%b len=%0d resp=%h expected ok=1 len=3 resp=%h",
                     ok, req_len, resp, {2'b00, 30'h101, 32'h0});
        end
    endtask

    task automatic test_read();
        bit ok;
        send_cmd(OP_SETADDR, 30'h100, 32'h0);
        push_txn(1'b0, 30'h100, 32'h0);
        slave_rdata = 32'h12345678;
        ack_delay   = 1;
        send_cmd(OP_READ, 30'h0, 32'h0);
        wait_not_busy(50, ok);
        checks++;
        if (!ok || req_len != 1 || resp !== {2'b00, 30'h101, 32'h12345678}) begin
            errors++;
            $display("[TB] FAIL read_done ok=%b len=%0d resp=%h expected ok=1 len=1 resp=%h",
                     ok, req_len, resp, {2'b00, 30'h101, 32'h12345678});
        end
    endtask

    task automatic test_timeout();
        bit ok;
        send_cmd(OP_SETADDR, 30'h40, 32'h0);
        push_txn(1'b0, 30'h40, 32'h0);
        ack_delay   = 0;
        slave_rdata = 32'h0BADF00D;
        send_cmd(OP_READ, 30'h0, 32'h0);
        wait_not_busy(50, ok);
        checks++;
        if (!ok || req_len != 4 || resp !== {2'b01, 30'h40, 32'h12345678}) begin
            errors++;
            $display("[TB] FAIL timeout ok=%b len=%0d resp=%h expected ok=1 len=4 resp=%h",
                     ok, req_len, resp, {2'b01, 30'h40, 32'h12345678});
        end
        send_cmd(OP_NOP, 30'h0, 32'h1);
        checks++;
        if (resp !== {2'b00, 30'h40, 32'h12345678}) begin
            errors++;
            $display("[TB] FAIL err_clear resp=%h expected=%h", resp, {2'b00, 30'h40, 32'h12345678});
        end
        push_txn(1'b0, 30'h40, 32'h0);
        ack_delay   = 4;
        slave_rdata = 32'hA5A50001;
        send_cmd(OP_READ, 30'h0, 32'h0);
        wait_not_busy(50, ok);
        checks++;
        if (!ok || req_len != 4 || resp !== {2'b00, 30'h41, 32'hA5A50001}) begin
            errors++;
            $display("[TB] FAIL ack_at_expiry ok=%b len=%0d resp=%h expected ok=1 len=4 resp=%h",
                     ok, req_len, resp, {2'b00, 30'h41, 32'hA5A50001});
        end
    endtask

    task automatic test_overrun();
        bit ok;
        send_cmd(OP_SETADDR, 30'h200, 32'h0);
        push_txn(1'b0, 30'h200, 32'h0);
        slave_rdata = 32'hCAFEF00D;
        ack_delay   = 3;
        send_cmd(OP_READ, 30'h0, 32'h0);
        send_cmd(OP_SETADDR, 30'h5, 32'h0);
        checks++;
        if (resp[63:62] !== 2'b11 || resp[61:32] !== 30'h200) begin
            errors++;
            $display("[TB] FAIL overrun_err busy_err=%b ptr=%h expected 11 ptr=%h", resp[63:62], resp[61:32], 30'h200);
        end
        wait_not_busy(50, ok);
        checks++;
        if (!ok || resp !== {2'b01, 30'h201, 32'hCAFEF00D}) begin
            errors++;
            $display("[TB] FAIL overrun_done ok=%b resp=%h expected=%h", ok, resp, {2'b01, 30'h201, 32'hCAFEF00D});
        end
        send_cmd(OP_NOP, 30'h0, 32'h1);
    endtask

    task automatic test_back_to_back();
        bit ok;
        send_cmd(OP_SETADDR, 30'h10, 32'h0);
        push_txn(1'b1, 30'h10, 32'h11111111);
        push_txn(1'b1, 30'h11, 32'h22222222);
        ack_delay = 1;
        send_cmd(OP_WRITE, 30'h0, 32'h11111111);
        tick();
        send_cmd(OP_WRITE, 30'h0, 32'h22222222);
        wait_not_busy(50, ok);
        checks++;
        if (!ok || resp !== {2'b00, 30'h12, 32'hCAFEF00D} || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL back_to_back ok=%b resp=%h pending=%0d expected resp=%h pending=0",
                     ok, resp, exp_q.size(), {2'b00, 30'h12, 32'hCAFEF00D});
        end
    endtask

    task automatic test_reset_mid();
        push_txn(1'b0, 30'h12, 32'h0);
        ack_delay = 0;
        send_cmd(OP_READ, 30'h0, 32'h0);
        tick();
        reset_n = 1'b0;
        tick();
        checks++;
        if (bus_req !== 1'b0 || resp !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_mid req=%b resp=%h expected req=0 resp=0", bus_req, resp);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        s_cmd = {OP_SETADDR, 30'h13, 32'h0};
        s_stb = 1'b1;
        tick();
        s_stb = 1'b0;
        checks++;
        if (s_resp[61:32] !== 30'h3) begin
            errors++;
            $display("[TB] FAIL small_trunc ptr=%h expected=%h", s_resp[61:32], 30'h3);
        end
        s_cmd = {OP_SETADDR, 30'hF, 32'h0};
        s_stb = 1'b1;
        tick();
        s_cmd = {OP_WRITE, 30'h0, 32'h00000055};
        tick();
        s_stb = 1'b0;
        checks++;
        if (s_req !== 1'b1 || s_we !== 1'b1 || s_addr !== 4'hF || s_wdata !== 32'h55) begin
            errors++;
            $display("[TB] FAIL small_write req=%b we=%b addr=%h wdata=%h expected 1 1 f 00000055",
                     s_req, s_we, s_addr, s_wdata);
        end
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        checks++;
        if (s_req !== 1'b0 || s_resp !== 64'h0) begin
            errors++;
            $display("[TB] FAIL small_wrap req=%b resp=%h expected req=0 resp=0", s_req, s_resp);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_bus_bridge.md
# jtag_bus_bridge

Command executor downstream of a 64-bit JTAG user register. It consumes the parallel word and its strobe, already synchronised to sysclk, and performs single-word reads and writes on a simple req/ack memory bus, with an auto-incrementing address pointer. It returns a registered status/read-data word that the JTAG register shifts out on its next capture. This lets host Tcl scripts peek and poke system memory and peripherals.

## Interface
Parameters:
- ADDR_BITS, 30, width of word address pointer and bus_addr; legal 1..30
- TIMEOUT, 255, max cycles bus_req waits for bus_ack before abort; legal 1..65535

Ports:
- sysclk  in  1  system clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- cmd  in  64  command word from JTAG register q
- cmd_stb  in  1  one-cycle strobe: cmd valid this cycle
- resp  out  64  status/data word to JTAG register d
- bus_req  out  1  bus request, held until ack or timeout
- bus_we  out  1  1 = write, 0 = read; valid while bus_req
- bus_addr  out  ADDR_BITS  word address; valid while bus_req
- bus_wdata  out  32  write data; valid while bus_req
- bus_rdata  in  32  read data; valid when bus_ack
- bus_ack  in  1  one-cycle completion from slave

## Operation
- Command fields: cmd[63:62] op, cmd[61:32] address field, cmd[31:0] data.
- Op 00 NOP: no bus activity. If cmd[0]=1, clear the sticky err flag.
- Op 01 SETADDR: ptr <= cmd[32+ADDR_BITS-1:32].
- Op 10 WRITE: bus write of cmd[31:0] to ptr. On ack, ptr increments.
- Op 11 READ: bus read from ptr. On ack, rdata_q <= bus_rdata and ptr increments.
- ptr increments modulo 2^ADDR_BITS; all-ones wraps to 0.
- resp[63] = busy (state BUS). resp[62] = err (sticky). resp[61:32] = ptr, zero-extended. resp[31:0] = rdata_q.
- FSM states:
  - IDLE: a cmd_stb carrying op 10 or 11 latches addr, we and wdata, loads the timeout counter, and goes to BUS. Ops 00 and 01 execute in place and stay in IDLE.
  - BUS: bus_req=1. On bus_ack, complete the access and go to IDLE. If the counter expires without ack, drop req, set err, leave ptr and rdata_q unchanged, and go to IDLE.
- cmd_stb while in BUS (overrun): the command is discarded and err is set. This includes SETADDR; ptr is untouched.
- bus_ack in the same cycle the timeout expires: the ack wins, the access completes normally, and err is not set.
- bus_ack while in IDLE is ignored.
- Reset mid-access: bus_req drops on the next edge with reset_n=0. No completion is recorded.

## Timing
- Reset values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, ptr 0, rdata_q 0, err 0, so resp = 0.
- cmd_stb in cycle N gives bus_req=1, with addr/we/wdata stable, from cycle N+1.
- bus_ack sampled high in cycle M gives bus_req=0 and updated resp (ptr+1, rdata_q, busy=0) in cycle M+1. Minimum access is 2 cycles, strobe to idle.
- Timeout: ack absent for TIMEOUT consecutive BUS cycles gives bus_req=0 and err=1 on the following edge.
- SETADDR and NOP take effect in cycle N+1. A new cmd_stb is accepted in any IDLE cycle, including the cycle right after completion.
- resp changes only on sysclk edges. The JTAG side samples it on capture; quasi-static use is the host's responsibility.

## Structure
- Package jtag_bridge_pkg holds:
  - op encodings: OP_NOP, OP_SETADDR, OP_WRITE, OP_READ
  - cmd/resp field bit positions
  - state enum: IDLE, BUS
- Single module. One FSM, timeout counter, ptr register. No sub-module is warranted; the timeout counter is too small to split out.

## Test plan
- Reset, then NOP: resp=0. bus_req never asserts.
- SETADDR 0x100, WRITE 0xDEADBEEF, slave acks after 3 cycles: bus_addr=0x100, bus_we=1, bus_wdata=0xDEADBEEF. Afterwards resp[61:32]=0x101, err=0.
- SETADDR 0x100, READ with slave returning 0x12345678 and immediate ack: bus_req high exactly 1 cycle. resp[31:0]=0x12345678, ptr=0x101.
- TIMEOUT=4, READ with no ack: bus_req high 4 cycles, then err=1, ptr unchanged. Then NOP with cmd[0]=1 clears err.
- READ pending, second cmd_stb (SETADDR 0x5) during BUS: err=1, ptr is unchanged by the SETADDR and only increments on the read's ack.
- ADDR_BITS=4, SETADDR 0xF, WRITE acked: ptr wraps to 0. Separately, assert reset_n=0 mid-BUS: bus_req=0 next cycle and resp=0.
